// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron BRAM sequencer.
package perceptron_pkg;

    localparam int unsigned BRAM_AW = 9;
    localparam int unsigned BRAM_DW = 32;
    localparam int unsigned X_LSB   = 0;
    localparam int unsigned W_LSB   = 16;
    localparam int unsigned Y_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMPUTE,
        WRITE,
        DONE
    } state_t;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable down-counter with a zero flag; shared by the fetch, drain and compute waits.
module seq_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero_c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/perceptron_sequencer.sv
// Runs one perceptron evaluation out of BRAM: fetch N words, settle, compute, write y back.
// Optional macro PERCEPTRON_SEQ_FIRE_WB_EN writes the fire flag into bit 16 and adds fire_q.
module perceptron_sequencer
    import perceptron_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned LOAD_LAT = 3,
    parameter int unsigned COMP_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BRAM_AW-1:0]   base_addr,
    output logic                 busy,
    output logic                 done,
    output logic [BRAM_AW-1:0]   bram_addr,
    output logic                 bram_we,
    output logic [BRAM_DW-1:0]   bram_wdata,
    output logic                 perceptron_enable,
    input  logic [Y_W-1:0]       perceptron_y,
    input  logic                 perceptron_fire,
    output logic [Y_W-1:0]       result
`ifdef PERCEPTRON_SEQ_FIRE_WB_EN
    ,
    output logic                 fire_q
`endif
);

    localparam int unsigned CNT_MAX = max3(N, LOAD_LAT, COMP_LAT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state;
    state_t             state_next;
    logic [BRAM_AW-1:0] base_q;
    logic [BRAM_AW-1:0] end_addr;

    logic               cnt_load;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt_load_value;
    logic [CNT_W-1:0]   unused_cnt;
    logic               cnt_zero;

    logic               busy_n;
    logic               done_n;
    logic [BRAM_AW-1:0] addr_n;
    logic               we_n;
    logic [BRAM_DW-1:0] wdata_n;
    logic               enable_n;
    logic [Y_W-1:0]     result_n;
`ifdef PERCEPTRON_SEQ_FIRE_WB_EN
    logic               fire_n;
`else
    logic               unused_fire;
    assign unused_fire = perceptron_fire;
`endif

    seq_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .count      (unused_cnt),
        .zero_c     (cnt_zero)
    );

    // Address parked outside the fetched block; also the write-back location.
    assign end_addr = base_q + BRAM_AW'(N);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && start) begin
                base_q <= base_addr;
            end
        end
    end

    // Next state and wait-counter control; each wait loads its length minus one.
    always_comb begin
        state_next     = state;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = FETCH;
                    cnt_load       = 1'b1;
                    cnt_load_value = CNT_W'(N - 1);
                end
            end
            FETCH: begin
                if (cnt_zero) begin
                    state_next     = DRAIN;
                    cnt_load       = 1'b1;
                    cnt_load_value = CNT_W'(LOAD_LAT - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    state_next     = COMPUTE;
                    cnt_load       = 1'b1;
                    cnt_load_value = CNT_W'(COMP_LAT - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            COMPUTE: begin
                if (cnt_zero) begin
                    state_next = WRITE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed for the state being entered so the registers line up with it.
    always_comb begin
        busy_n   = (state_next != IDLE);
        done_n   = (state_next == DONE);
        enable_n = (state == DRAIN) && (state_next == COMPUTE);
        addr_n   = bram_addr;
        we_n     = 1'b0;
        wdata_n  = bram_wdata;
        result_n = result;
`ifdef PERCEPTRON_SEQ_FIRE_WB_EN
        fire_n   = fire_q;
`endif
        case (state_next)
            FETCH:   addr_n = (state == IDLE) ? base_addr : bram_addr + BRAM_AW'(1);
            DRAIN,
            COMPUTE,
            DONE:    addr_n = end_addr;
            WRITE: begin
                addr_n                    = end_addr;
                we_n                      = 1'b1;
                wdata_n                   = '0;
                wdata_n[X_LSB +: Y_W]     = perceptron_y;
                result_n                  = perceptron_y;
`ifdef PERCEPTRON_SEQ_FIRE_WB_EN
                wdata_n[W_LSB]            = perceptron_fire;
                fire_n                    = perceptron_fire;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy              <= 1'b0;
            done              <= 1'b0;
            bram_addr         <= '0;
            bram_we           <= 1'b0;
            bram_wdata        <= '0;
            perceptron_enable <= 1'b0;
            result            <= '0;
`ifdef PERCEPTRON_SEQ_FIRE_WB_EN
            fire_q            <= 1'b0;
`endif
        end else begin
            busy              <= busy_n;
            done              <= done_n;
            bram_addr         <= addr_n;
            bram_we           <= we_n;
            bram_wdata        <= wdata_n;
            perceptron_enable <= enable_n;
            result            <= result_n;
`ifdef PERCEPTRON_SEQ_FIRE_WB_EN
            fire_q            <= fire_n;
`endif
        end
    end

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_perceptron_sequencer;

`ifdef PERCEPTRON_SEQ_FIRE_WB_EN
    localparam bit FIRE_EN = 1'b1;
`else
    localparam bit FIRE_EN = 1'b0;
`endif
    localparam logic [31:0] IDLE_MASK = 32'h1E00_0000;

    typedef struct {
        int          cyc;
        logic [31:0] vec;
        logic        chk_w;
        logic [31:0] wdata;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [8:0]  base1 = '0, base2 = '0;
    logic [15:0] y = '0;
    logic        fire = 1'b0;

    logic        busy1, done1, we1, en1, fq1;
    logic        busy2, done2, we2, en2, fq2;
    logic [8:0]  addr1, addr2;
    logic [31:0] wd1, wd2;
    logic [15:0] res1, res2;

    logic [31:0] act_vec [2];
    logic [31:0] act_wd  [2];
    ent_t        q [2][$];
    logic [15:0] r_prev  [2];
    logic        fr_prev [2];
    ent_t        mon_e;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    perceptron_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start1), .base_addr(base1),
        .busy(busy1), .done(done1), .bram_addr(addr1), .bram_we(we1),
        .bram_wdata(wd1), .perceptron_enable(en1), .perceptron_y(y),
        .perceptron_fire(fire), .result(res1)
`ifdef PERCEPTRON_SEQ_FIRE_WB_EN
        , .fire_q(fq1)
`endif
    );

    perceptron_sequencer #(.N(1), .LOAD_LAT(1), .COMP_LAT(1)) u_small (
        .clk(clk), .rst(rst), .start(start2), .base_addr(base2),
        .busy(busy2), .done(done2), .bram_addr(addr2), .bram_we(we2),
        .bram_wdata(wd2), .perceptron_enable(en2), .perceptron_y(y),
        .perceptron_fire(fire), .result(res2)
`ifdef PERCEPTRON_SEQ_FIRE_WB_EN
        , .fire_q(fq2)
`endif
    );

`ifndef PERCEPTRON_SEQ_FIRE_WB_EN
    assign fq1 = 1'b0;
    assign fq2 = 1'b0;
`endif

    always_comb begin
        act_vec[0] = {2'b00, fq1, busy1, done1, en1, we1, addr1, res1};
        act_vec[1] = {2'b00, fq2, busy2, done2, en2, we2, addr2, res2};
        act_wd[0]  = wd1;
        act_wd[1]  = wd2;
    end

    task automatic cmp(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic ent_t mk(input int t0, input int k, input int b, input logic [15:0] yy,
                                input logic f, input logic [15:0] r, input logic fr,
                                input int n, input int ll, input int cl);
        ent_t        e;
        int          len, wk;
        logic [8:0]  a;
        logic [15:0] res;
        logic        fe, fq;
        len = n + ll + cl + 2;
        wk  = n + ll + cl + 1;
        fe  = FIRE_EN ? f : 1'b0;
        a   = (k <= n) ? 9'(b + k - 1) : 9'(b + n);
        res = (k >= wk) ? yy : r;
        fq  = (k >= wk) ? fe : fr;
        e.cyc   = t0 + k;
        e.vec   = {2'b00, fq, 1'b1, 1'(k == len), 1'(k == n + ll + 1), 1'(k == wk), a, res};
        e.chk_w = (k == wk);
        e.wdata = {15'd0, fe, yy};
        return e;
    endfunction

    function automatic ent_t mk_zero(input int c);
        ent_t e;
        e.cyc   = c;
        e.vec   = '0;
        e.chk_w = 1'b1;
        e.wdata = '0;
        return e;
    endfunction

    task automatic push_run(input int i, input int t0, input int b, input logic [15:0] yy, input logic f);
        int n, ll, cl;
        n  = (i == 0) ? 8 : 1;
        ll = (i == 0) ? 3 : 1;
        cl = (i == 0) ? 2 : 1;
        for (int k = 1; k <= n + ll + cl + 2; k++)
            q[i].push_back(mk(t0, k, b, yy, f, r_prev[i], fr_prev[i], n, ll, cl));
        r_prev[i]  = yy;
        fr_prev[i] = FIRE_EN ? f : 1'b0;
    endtask

    // Monitor: scheduled cycles get a full compare, all others must look idle.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                if (q[i].size() > 0 && q[i][0].cyc < cyc) begin
                    mon_e = q[i].pop_front();
                    cmp("stale_entry", cyc, 32'(cyc), 32'(mon_e.cyc));
                end
                if (q[i].size() > 0 && q[i][0].cyc == cyc) begin
                    mon_e = q[i].pop_front();
                    cmp(i == 0 ? "outputs" : "outputs_small", cyc, act_vec[i], mon_e.vec);
                    if (mon_e.chk_w)
                        cmp(i == 0 ? "wdata" : "wdata_small", cyc, act_wd[i], mon_e.wdata);
                end else begin
                    cmp(i == 0 ? "idle" : "idle_small", cyc, act_vec[i] & IDLE_MASK, 32'h0);
                end
            end
        end
    end

    initial begin
        int t;
        for (int i = 0; i < 2; i++) begin
            r_prev[i]  = '0;
            fr_prev[i] = 1'b0;
            for (int c = 1; c <= 3; c++) q[i].push_back(mk_zero(c));
        end
        step(3);
        rst = 1'b0;
        step(2);

        // Default run from base 0.
        t = cyc; base1 = 9'd0; y = 16'h1234; fire = 1'b0; start1 = 1'b1;
        push_run(0, t, 0, 16'h1234, 1'b0);
        step(1); start1 = 1'b0;
        step(20);

        // Address wrap past 511, fire set.
        t = cyc; base1 = 9'd508; y = 16'hBEEF; fire = 1'b1; start1 = 1'b1;
        push_run(0, t, 508, 16'hBEEF, 1'b1);
        step(1); start1 = 1'b0;
        step(20);

        // Start held: accepted every 16 cycles only.
        t = cyc; base1 = 9'd100; y = 16'h0A0A; fire = 1'b0; start1 = 1'b1;
        push_run(0, t,      100, 16'h0A0A, 1'b0);
        push_run(0, t + 16, 100, 16'h0B0B, 1'b0);
        push_run(0, t + 32, 100, 16'h0C0C, 1'b1);
        step(15); y = 16'h0B0B;
        step(16); y = 16'h0C0C; fire = 1'b1;
        step(2);  start1 = 1'b0;
        step(20);

        // Reset during DRAIN aborts the run.
        t = cyc; base1 = 9'd50; y = 16'h7777; fire = 1'b0; start1 = 1'b1;
        push_run(0, t, 50, 16'h7777, 1'b0);
        step(1); start1 = 1'b0;
        step(9);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            while (q[i].size() > 0 && q[i][q[i].size() - 1].cyc > t + 10) void'(q[i].pop_back());
            q[i].push_back(mk_zero(t + 11));
            r_prev[i]  = '0;
            fr_prev[i] = 1'b0;
        end
        step(1); rst = 1'b0;
        step(3);

        t = cyc; base1 = 9'd200; y = 16'h5555; fire = 1'b0; start1 = 1'b1;
        push_run(0, t, 200, 16'h5555, 1'b0);
        step(1); start1 = 1'b0;
        step(20);

        // Minimal configuration: done 5 cycles after acceptance, write wraps to 0.
        t = cyc; base2 = 9'd511; y = 16'h00AA; fire = 1'b1; start2 = 1'b1;
        push_run(1, t, 511, 16'h00AA, 1'b1);
        step(1); start2 = 1'b0;
        step(10);

        for (int i = 0; i < 200 && (q[0].size() + q[1].size()) > 0; i++) step(1);
        if ((q[0].size() + q[1].size()) > 0)
            cmp("queue_drain", cyc, 32'(q[0].size() + q[1].size()), 32'h0);
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
